// File: rtl/uart_bridge_pkg.sv
// Shared definitions for the UART-to-SPI bridge: byte width and the
// transmit arbiter state encoding.
package uart_bridge_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HOLD      = 3'd1,
        ACK       = 3'd2,
        WAIT_LOW  = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational circular priority picker: returns the first set bit of
// valid, scanning upward from ptr and wrapping at N-1.
module rr_pick #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid,
    input  logic [PW-1:0] ptr,
    output logic          found,
    output logic [PW-1:0] winner
);

    logic [2*N-1:0] rotated;

    // Rotating a doubled copy puts the highest-priority candidate at bit 0.
    always_comb begin
        found   = 1'b0;
        winner  = '0;
        rotated = {valid, valid} >> ptr;
        for (int k = 0; k < N; k++) begin
            if (!found && rotated[k]) begin
                found  = 1'b1;
                winner = PW'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART transmitter among
// NUM_REQ byte streams, sequencing the transmitter's ready/ack handshake.
module uart_tx_arbiter
    import uart_bridge_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int MAX_PKT = 16
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic [BYTE_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [BYTE_W-1:0]         tx_data,
    output logic                      tx_ack,
    input  logic                      tx_ready,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t              state;
    state_t              state_nx;
    logic [PW-1:0]       ptr;
    logic [PW-1:0]       owner;
    logic [PW-1:0]       sel;
    logic [PW-1:0]       winner;
    logic                found;
    logic                accept;
    logic                pkt_done;
    logic                last_q;
    logic [7:0]          count;
    logic [NUM_REQ-1:0]  valid_sh;
    logic [NUM_REQ-1:0]  last_sh;
    logic [BYTE_W-1:0]   sel_byte;

    rr_pick #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_pick (
        .valid  (req_valid),
        .ptr    (ptr),
        .found  (found),
        .winner (winner)
    );

    assign tx_ack   = (state == ACK);
    assign busy     = (state != IDLE);
    assign pkt_done = last_q || (count == 8'(MAX_PKT));

    // Next state plus the accept decision; sel is the requester being served.
    always_comb begin
        state_nx  = state;
        accept    = 1'b0;
        sel       = owner;
        valid_sh  = req_valid >> owner;
        case (state)
            IDLE: begin
                sel = winner;
                if (found && tx_ready) begin
                    accept   = 1'b1;
                    state_nx = ACK;
                end
            end
            HOLD: begin
                if (valid_sh[0] && tx_ready) begin
                    accept   = 1'b1;
                    state_nx = ACK;
                end
            end
            ACK:       state_nx = WAIT_LOW;
            WAIT_LOW:  if (!tx_ready) state_nx = WAIT_HIGH;
            WAIT_HIGH: if (tx_ready)  state_nx = pkt_done ? IDLE : HOLD;
            default:   state_nx = IDLE;
        endcase
        if (sys_rst) begin
            accept = 1'b0;
        end
        last_sh   = req_last >> sel;
        sel_byte  = BYTE_W'(req_data >> (int'(sel) * BYTE_W));
        req_ready = accept ? (NUM_REQ'(1) << sel) : '0;
    end

    // The pointer only advances on packet release, so an owner that stalls
    // in HOLD keeps its grant until it resumes.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state   <= IDLE;
            ptr     <= '0;
            owner   <= '0;
            count   <= '0;
            last_q  <= 1'b0;
            tx_data <= '0;
            grant   <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                tx_data <= sel_byte;
                last_q  <= last_sh[0];
                if (state == IDLE) begin
                    owner <= winner;
                    grant <= NUM_REQ'(1) << winner;
                    count <= 8'd1;
                end else begin
                    count <= count + 8'd1;
                end
            end
            if (state == WAIT_HIGH && tx_ready && pkt_done) begin
                ptr   <= (owner == PW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
                grant <= '0;
            end
        end
    end

endmodule
